// File: rtl/key_event_ctrl_pkg.sv
// Shared state encoding and default timing for the key event sequencer.
// Shared with the key_fliter debounce stage.
package key_event_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } key_state_e;

    localparam int unsigned DEF_CNT_W    = 26;
    localparam int unsigned DEF_LONG_CYC = 50_000_000;
    localparam int unsigned DEF_DBL_CYC  = 15_000_000;
    localparam int unsigned DEF_REP_CYC  = 10_000_000;

endpackage

// File: rtl/key_event_ctrl_if.sv
// Strobe inputs and event outputs between the key_fliter stage and the sequencer.
interface key_event_ctrl_if;

    logic en;
    logic key_flag;
    logic key_state;
    logic short_pulse;
    logic long_pulse;
    logic dbl_pulse;
    logic rep_pulse;
    logic busy;

    modport master (
        output en, key_flag, key_state,
        input  short_pulse, long_pulse, dbl_pulse, rep_pulse, busy
    );

    modport slave (
        input  en, key_flag, key_state,
        output short_pulse, long_pulse, dbl_pulse, rep_pulse, busy
    );

endinterface

// File: rtl/key_event_ctrl_timer.sv
// Saturating interval counter with synchronous clear and a terminal compare
// against a limit selected by the caller.
module key_evt_timer #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/key_event_ctrl.sv
// Classifies debounced key gestures into short, long, double-click and
// auto-repeat single-cycle event pulses.
module key_event_ctrl
    import key_event_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned LONG_CYC = DEF_LONG_CYC,
    parameter int unsigned DBL_CYC  = DEF_DBL_CYC,
    parameter int unsigned REP_CYC  = DEF_REP_CYC,
    parameter bit          REP_EN   = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    key_event_ctrl_if.slave bus
);

    key_state_e       state, state_n;
    logic             press, release_s;
    logic             clr, tc, rep_restart;
    logic [CNT_W-1:0] limit;
    logic             short_n, long_n, dbl_n, rep_n;
    logic             short_q, long_q, dbl_q, rep_q, busy_q;

    assign press     = bus.key_flag & ~bus.key_state;
    assign release_s = bus.key_flag &  bus.key_state;

    key_evt_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .limit (limit),
        .tc    (tc)
    );

    always_comb begin
        state_n     = state;
        short_n     = 1'b0;
        long_n      = 1'b0;
        dbl_n       = 1'b0;
        rep_n       = 1'b0;
        rep_restart = 1'b0;

        case (state)
            PRESS1:  limit = CNT_W'(LONG_CYC - 1);
            WAIT2:   limit = CNT_W'(DBL_CYC - 1);
            HOLD:    limit = CNT_W'(REP_CYC - 1);
            default: limit = '1;
        endcase

        if (!bus.en) begin
            state_n = IDLE;
        end else begin
            // Strobes are tested before the terminal count so they win a tie.
            case (state)
                IDLE: begin
                    if (press) state_n = PRESS1;
                end
                PRESS1: begin
                    if (release_s) begin
                        state_n = WAIT2;
                    end else if (tc) begin
                        state_n = HOLD;
                        long_n  = 1'b1;
                    end
                end
                WAIT2: begin
                    if (press) begin
                        state_n = PRESS2;
                    end else if (tc) begin
                        state_n = IDLE;
                        short_n = 1'b1;
                    end
                end
                PRESS2: begin
                    if (release_s) begin
                        state_n = IDLE;
                        dbl_n   = 1'b1;
                    end
                end
                HOLD: begin
                    if (release_s) begin
                        state_n = IDLE;
                    end else if (REP_EN && tc) begin
                        rep_n       = 1'b1;
                        rep_restart = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        clr = !bus.en || rep_restart || (state_n != state);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            short_q <= short_n;
            long_q  <= long_n;
            dbl_q   <= dbl_n;
            rep_q   <= rep_n;
            busy_q  <= (state_n != IDLE);
        end
    end

    assign bus.short_pulse = short_q;
    assign bus.long_pulse  = long_q;
    assign bus.dbl_pulse   = dbl_q;
    assign bus.rep_pulse   = rep_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed gestures plus random strobes, every cycle
// compared against a timestamp-based gesture model.
module tb_key_event_ctrl;

    localparam int LONG = 20;
    localparam int DBL  = 10;
    localparam int REP  = 5;

    logic clk = 1'b0;
    logic rst_n;
    key_event_ctrl_if bus();

    key_event_ctrl #(
        .CNT_W    (26),
        .LONG_CYC (LONG),
        .DBL_CYC  (DBL),
        .REP_CYC  (REP),
        .REP_EN   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_short, n_long, n_dbl, n_rep;
    int short_edge, long_edge, dbl_edge, strobe_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Gesture model: tracks what the user is doing and when the current phase began.
    bit m_active, m_down, m_second, m_long;
    int t0;
    bit e_short, e_long, e_dbl, e_rep;

    always begin
        @(posedge clk);
        cyc++;
        e_short = 0; e_long = 0; e_dbl = 0; e_rep = 0;
        begin
            bit pr, rl;
            pr = bus.key_flag & ~bus.key_state;
            rl = bus.key_flag &  bus.key_state;
            if (!rst_n || !bus.en) begin
                m_active = 0;
            end else if (!m_active) begin
                if (pr) begin
                    m_active = 1; m_down = 1; m_second = 0; m_long = 0; t0 = cyc;
                end
            end else if (m_long) begin
                if (rl) m_active = 0;
                else if (cyc - t0 == REP) begin e_rep = 1; t0 = cyc; end
            end else if (m_down && !m_second) begin
                if (rl) begin m_down = 0; t0 = cyc; end
                else if (cyc - t0 == LONG) begin e_long = 1; m_long = 1; t0 = cyc; end
            end else if (!m_down) begin
                if (pr) begin m_down = 1; m_second = 1; end
                else if (cyc - t0 == DBL) begin e_short = 1; m_active = 0; end
            end else begin
                if (rl) begin e_dbl = 1; m_active = 0; end
            end
        end
        #1;
        chk("short", bus.short_pulse, e_short);
        chk("long",  bus.long_pulse,  e_long);
        chk("dbl",   bus.dbl_pulse,   e_dbl);
        chk("rep",   bus.rep_pulse,   e_rep);
        chk("busy",  bus.busy,        m_active);
        if (bus.short_pulse === 1'b1) begin n_short++; short_edge = cyc; end
        if (bus.long_pulse  === 1'b1) begin n_long++;  long_edge  = cyc; end
        if (bus.dbl_pulse   === 1'b1) begin n_dbl++;   dbl_edge   = cyc; end
        if (bus.rep_pulse   === 1'b1) n_rep++;
    end

    task automatic clear_counts();
        n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0;
    endtask

    task automatic strobe(input logic st);
        bus.key_flag  = 1'b1;
        bus.key_state = st;
        strobe_edge   = cyc + 1;
        @(negedge clk);
        bus.key_flag  = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_counts(input string tag, input int s, input int l, input int d, input int r);
        chk({tag, "_nshort"}, n_short, s);
        chk({tag, "_nlong"},  n_long,  l);
        chk({tag, "_ndbl"},   n_dbl,   d);
        chk({tag, "_nrep"},   n_rep,   r);
        chk({tag, "_idle"},   bus.busy, 1'b0);
    endtask

    initial begin
        int press_edge, rel_edge;
        logic lvl;
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.key_flag = 1'b0;
        bus.key_state = 1'b1;
        clear_counts();
        gap(2);
        rst_n = 1'b1;
        gap(2);

        // 1: short press
        clear_counts();
        strobe(1'b0); gap(4); strobe(1'b1); rel_edge = strobe_edge; gap(20);
        expect_counts("t1", 1, 0, 0, 0);
        chk("t1_short_delay", short_edge - rel_edge, DBL);

        // 2: double click
        clear_counts();
        strobe(1'b0); gap(4); strobe(1'b1); gap(3);
        strobe(1'b0); gap(2); strobe(1'b1); rel_edge = strobe_edge; gap(15);
        expect_counts("t2", 0, 0, 1, 0);
        chk("t2_dbl_delay", dbl_edge - rel_edge, 0);

        // 3: long press with auto-repeat
        clear_counts();
        strobe(1'b0); press_edge = strobe_edge; gap(31); strobe(1'b1); gap(15);
        expect_counts("t3", 0, 1, 0, 2);
        chk("t3_long_delay", long_edge - press_edge, LONG);

        // 4: release on the long terminal-count cycle
        clear_counts();
        strobe(1'b0); gap(19); strobe(1'b1); rel_edge = strobe_edge; gap(15);
        expect_counts("t4", 1, 0, 0, 0);
        chk("t4_short_delay", short_edge - rel_edge, DBL);

        // 5: reset during WAIT2
        clear_counts();
        strobe(1'b0); gap(4); strobe(1'b1); gap(3);
        rst_n = 1'b0; gap(1); rst_n = 1'b1;
        gap(20);
        expect_counts("t5", 0, 0, 0, 0);

        // 6: enable dropped mid-press, then a normal press
        clear_counts();
        strobe(1'b0); gap(3);
        bus.en = 1'b0; gap(2); strobe(1'b1); gap(2); bus.en = 1'b1;
        gap(20);
        expect_counts("t6a", 0, 0, 0, 0);
        strobe(1'b0); gap(4); strobe(1'b1); gap(15);
        expect_counts("t6b", 1, 0, 0, 0);

        // Random strobes, enable drops and resets against the model
        lvl = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            gap($urandom_range(0, 26));
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rst_n = 1'b0; gap(1); rst_n = 1'b1;
            end else if (r < 7) begin
                bus.en = 1'b0; gap($urandom_range(1, 5)); bus.en = 1'b1;
            end else if (r < 17) begin
                strobe(1'($urandom_range(0, 1)));
            end else begin
                lvl = ~lvl;
                strobe(lvl);
            end
        end
        gap(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
